xgmii_rx_mac: RTL and testbench

- 10G Ethernet receive MAC. Consumes a 32-bit XGMII word stream from the PCS, or from tx_mac in loopback.
- Detects Start/preamble/SFD, strips them and the 4-byte FCS, and checks CRC-32, length and control-character errors.
- Emits the payload as a keep-qualified 32-bit stream with a last-beat marker and an error flag.

---
 rtl/xgmii_rx_mac.sv | 262 ++++++++++++++++++++++++++
 tb/tb_xgmii_rx_mac.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_mac.sv
// xgmii_rx_mac: 10G Ethernet receive MAC on a 32-bit XGMII word stream.
// In: i_clk, i_reset_n (async, active-high), i_xgmii_data/ctrl/valid.
// Out: o_data, o_data_keep, o_data_valid, o_data_last, o_data_err.
// Macro RX_MAC_CRC_CHECK_EN builds the CRC-32 check; without it the
// FCS is still stripped but never checked.
module xgmii_rx_mac #(
  parameter int XGMII_DATA_WIDTH  = 32,
  parameter int XGMII_CTRL_WIDTH  = XGMII_DATA_WIDTH / 8,
  parameter int O_DATA_WIDTH      = 32,
  parameter int O_DATA_KEEP_WIDTH = O_DATA_WIDTH / 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [XGMII_DATA_WIDTH-1:0]  i_xgmii_data,
  input  logic [XGMII_CTRL_WIDTH-1:0]  i_xgmii_ctrl,
  input  logic                         i_xgmii_valid,
  output logic [O_DATA_WIDTH-1:0]      o_data,
  output logic [O_DATA_KEEP_WIDTH-1:0] o_data_keep,
  output logic                         o_data_valid,
  output logic                         o_data_last,
  output logic                         o_data_err
);

  localparam logic [7:0]  C_START = 8'hFB;
  localparam logic [7:0]  C_TERM  = 8'hFD;
  localparam logic [31:0] W_START = 32'h555555FB;
  localparam logic [31:0] W_SFD   = 32'hD5555555;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] d1_q, d1_d, d2_q, d2_d;
  logic        d1_vld_q, d1_vld_d, d2_vld_q, d2_vld_d;
  logic [4:0]  words_q, words_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [3:0]  pend_keep_q, pend_keep_d;
  logic        pend_err_q, pend_err_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_keep_q, out_keep_d;
  logic        out_vld_q, out_vld_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;

  logic        term_hit;
  logic [1:0]  term_lane;
  logic        pre_ctrl;
  logic        start_w, sfd_w, start_l0;
  logic        crc_bad;
  logic        bad;

  assign start_w  = (i_xgmii_ctrl == 4'b0001) && (i_xgmii_data == W_START);
  assign sfd_w    = (i_xgmii_ctrl == 4'b0000) && (i_xgmii_data == W_SFD);
  assign start_l0 = i_xgmii_ctrl[0] && (i_xgmii_data[7:0] == C_START);

  // First Terminate wins; any control lane before it is a frame error.
  always_comb begin
    term_hit  = 1'b0;
    term_lane = 2'd0;
    pre_ctrl  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!term_hit && i_xgmii_ctrl[i]) begin
        if (i_xgmii_data[8*i +: 8] == C_TERM) begin
          term_hit  = 1'b1;
          term_lane = 2'(i);
        end else begin
          pre_ctrl = 1'b1;
        end
      end
    end
  end

`ifdef RX_MAC_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] c1, c2, c3, c4, crc_fin;

  function automatic logic [31:0] crc8(input logic [31:0] c,
                                       input logic [7:0]  b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    c1 = crc8(crc_q, i_xgmii_data[7:0]);
    c2 = crc8(c1, i_xgmii_data[15:8]);
    c3 = crc8(c2, i_xgmii_data[23:16]);
    c4 = crc8(c3, i_xgmii_data[31:24]);
    unique case (term_lane)
      2'd1:    crc_fin = c1;
      2'd2:    crc_fin = c2;
      2'd3:    crc_fin = c3;
      default: crc_fin = crc_q;
    endcase
    crc_bad = (crc_fin != 32'hDEBB20E3);
    crc_d   = crc_q;
    if (i_xgmii_valid) begin
      if (state_q == PREAMBLE && sfd_w)
        crc_d = 32'hFFFFFFFF;
      else if (state_q == DATA && !start_l0 && !term_hit)
        crc_d = c4;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset_n) begin
    if (i_reset_n) crc_q <= 32'hFFFFFFFF;
    else           crc_q <= crc_d;
  end
`else
  assign crc_bad = 1'b0;
`endif

  // 16 full words before Terminate is exactly the 64-byte minimum.
  assign bad = err_q | pre_ctrl | ~words_q[4] | crc_bad;

  always_comb begin
    state_d     = state_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d1_vld_d    = d1_vld_q;
    d2_vld_d    = d2_vld_q;
    words_d     = words_q;
    err_d       = err_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_keep_d = pend_keep_q;
    pend_err_d  = pend_err_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_vld_d   = 1'b0;
    out_last_d  = 1'b0;
    out_err_d   = 1'b0;
    if (i_xgmii_valid) begin
      // Tail beat left over from the previous Terminate.
      if (pend_q) begin
        pend_d     = 1'b0;
        out_vld_d  = 1'b1;
        out_data_d = pend_data_q;
        out_keep_d = pend_keep_q;
        out_last_d = 1'b1;
        out_err_d  = pend_err_q;
      end
      unique case (state_q)
        IDLE: begin
          if (start_w) state_d = PREAMBLE;
        end
        PREAMBLE: begin
          if (sfd_w) begin
            state_d  = DATA;
            d1_vld_d = 1'b0;
            d2_vld_d = 1'b0;
            words_d  = 5'd0;
            err_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          d1_vld_d = 1'b0;
          d2_vld_d = 1'b0;
          if (start_l0) begin
            // Abort: close on the oldest buffered word.
            state_d = PREAMBLE;
            if (d2_vld_q || d1_vld_q) begin
              out_vld_d  = 1'b1;
              out_data_d = d2_vld_q ? d2_q : d1_q;
              out_keep_d = 4'b1111;
              out_last_d = 1'b1;
              out_err_d  = 1'b1;
            end
          end else if (term_hit) begin
            state_d = IDLE;
            if (term_lane == 2'd0) begin
              // d1 is all FCS; d2 is the tail.
              if (d2_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = d2_q;
                out_keep_d = 4'b1111;
                out_last_d = 1'b1;
                out_err_d  = bad;
              end
            end else begin
              if (d2_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = d2_q;
                out_keep_d = 4'b1111;
              end
              // d1 holds k payload bytes below 4-k FCS bytes.
              if (d1_vld_q) begin
                pend_d      = 1'b1;
                pend_data_d = d1_q;
                pend_keep_d = ~(4'b1111 << term_lane);
                pend_err_d  = bad;
              end
            end
          end else begin
            if (d2_vld_q) begin
              out_vld_d  = 1'b1;
              out_data_d = d2_q;
              out_keep_d = 4'b1111;
            end
            d2_d     = d1_q;
            d2_vld_d = d1_vld_q;
            d1_d     = i_xgmii_data;
            d1_vld_d = 1'b1;
            words_d  = words_q[4] ? words_q : words_q + 5'd1;
            err_d    = err_q | (|i_xgmii_ctrl);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset_n) begin
    if (i_reset_n) begin
      state_q     <= IDLE;
      d1_q        <= '0;
      d2_q        <= '0;
      d1_vld_q    <= 1'b0;
      d2_vld_q    <= 1'b0;
      words_q     <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_keep_q <= '0;
      pend_err_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d1_vld_q    <= d1_vld_d;
      d2_vld_q    <= d2_vld_d;
      words_q     <= words_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_keep_q <= pend_keep_d;
      pend_err_q  <= pend_err_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  assign o_data       = out_data_q;
  assign o_data_keep  = out_keep_q;
  assign o_data_valid = out_vld_q;
  assign o_data_last  = out_last_q;
  assign o_data_err   = out_err_q;

endmodule

// File: tb/tb_xgmii_rx_mac.sv
// tb_xgmii_rx_mac: directed frames into xgmii_rx_mac with a beat
// scoreboard filled at drive time and drained by an output monitor.
module tb_xgmii_rx_mac;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] xd;
  logic [3:0]  xc;
  logic        xv;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_valid, o_last, o_err;

  always #5 clk = ~clk;

  xgmii_rx_mac dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_xgmii_data  (xd),
    .i_xgmii_ctrl  (xc),
    .i_xgmii_valid (xv),
    .o_data        (o_data),
    .o_data_keep   (o_keep),
    .o_data_valid  (o_valid),
    .o_data_last   (o_last),
    .o_data_err    (o_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

`ifdef RX_MAC_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{k[l]}};
    return m;
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0]  b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (o_valid) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: got data %h, expected none", o_data);
      end
      if (exp_q.size() > 0) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_keep", {28'd0, o_keep}, {28'd0, e.keep});
        chk("beat_data", o_data & kmask(e.keep), e.data & kmask(e.keep));
        chk("beat_last", {31'd0, o_last}, {31'd0, e.last});
        chk("beat_err", {31'd0, o_err}, {31'd0, e.err});
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic [3:0] c,
                       input bit gap);
    if (gap) begin
      @(negedge clk);
      xv = 1'b0;
      xd = $urandom;
      xc = 4'($urandom);
    end
    @(negedge clk);
    xv = 1'b1;
    xd = d;
    xc = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'h07070707, 4'hF, 1'b0);
  endtask

  task automatic send_frame(input int len, input int flip,
                            input int fe_word, input bit exp_err,
                            input bit gap);
    logic [7:0]  wb[$];
    logic        wc[$];
    logic [31:0] c, w;
    logic [3:0]  wk;
    beat_t       b;
    int          total, idx;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      wb.push_back(8'(i));
      wc.push_back(1'b0);
      c = crc_upd(c, 8'(i));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) begin
      wb.push_back(c[8*i +: 8]);
      wc.push_back(1'b0);
    end
    if (flip >= 0) wb[flip] = wb[flip] ^ 8'h08;
    if (fe_word >= 0) begin
      wb[fe_word*4+2] = 8'hFE;
      wc[fe_word*4+2] = 1'b1;
    end
    for (int i = 0; i < len; i += 4) begin
      b = '0;
      for (int l = 0; l < 4; l++)
        if (i + l < len) begin
          b.data[8*l +: 8] = wb[i+l];
          b.keep[l] = 1'b1;
        end
      b.last = (i + 4 >= len);
      b.err  = b.last & exp_err;
      exp_q.push_back(b);
    end
    drive(32'h555555FB, 4'b0001, gap);
    drive(32'hD5555555, 4'b0000, gap);
    total = wb.size();
    for (int wi = 0; wi <= total / 4; wi++) begin
      for (int l = 0; l < 4; l++) begin
        idx = wi * 4 + l;
        if (idx < total) begin
          w[8*l +: 8] = wb[idx];
          wk[l] = wc[idx];
        end else if (idx == total) begin
          w[8*l +: 8] = 8'hFD;
          wk[l] = 1'b1;
        end else begin
          w[8*l +: 8] = 8'h07;
          wk[l] = 1'b1;
        end
      end
      drive(w, wk, gap);
    end
    idle(3);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    beat_t b;
    reset_n = 1'b1;
    xv = 1'b0;
    xd = '0;
    xc = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_last", {31'd0, o_last}, 0);
    chk("rst_err", {31'd0, o_err}, 0);
    chk("rst_data", o_data, 0);
    chk("rst_keep", {28'd0, o_keep}, 0);
    @(negedge clk);
    reset_n = 1'b0;
    idle(4);

    // 60 payload + FCS, Terminate in lane 0
    send_frame(60, -1, -1, 1'b0, 1'b0);
    drain("drain_64B");
    // 61 payload + FCS, Terminate in lane 1
    send_frame(61, -1, -1, 1'b0, 1'b0);
    drain("drain_65B");
    // payload bit flip
    send_frame(61, 10, -1, CRC_ON, 1'b0);
    drain("drain_crc_flip");
    // 0xFE control char in lane 2
    send_frame(64, -1, 5, 1'b1, 1'b0);
    drain("drain_fe_char");
    // lanes 1,2,3 Terminate positions
    send_frame(62, -1, -1, 1'b0, 1'b0);
    send_frame(63, -1, -1, 1'b0, 1'b0);
    drain("drain_62_63");
    // bad SFD then good frame
    drive(32'h555555FB, 4'b0001, 1'b0);
    drive(32'hD5555554, 4'b0000, 1'b0);
    idle(4);
    send_frame(60, -1, -1, 1'b0, 1'b0);
    drain("drain_bad_sfd");
    // runt
    send_frame(40, -1, -1, 1'b1, 1'b0);
    drain("drain_runt");
    // valid toggling
    send_frame(61, -1, -1, 1'b0, 1'b1);
    drain("drain_gap");
    // early Start: 10 words, oldest buffered closes with err
    drive(32'h555555FB, 4'b0001, 1'b0);
    drive(32'hD5555555, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        b.data = {4{8'(8'h80 + i)}};
        b.keep = 4'hF;
        b.last = (i == 8);
        b.err  = (i == 8);
        exp_q.push_back(b);
      end
      drive({4{8'(8'h80 + i)}}, 4'b0000, 1'b0);
    end
    send_frame(60, -1, -1, 1'b0, 1'b0);
    drain("drain_early_start");
    // reset mid-frame
    drive(32'h555555FB, 4'b0001, 1'b0);
    drive(32'hD5555555, 4'b0000, 1'b0);
    drive(32'h11111111, 4'b0000, 1'b0);
    drive(32'h22222222, 4'b0000, 1'b0);
    @(negedge clk);
    xv = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", {31'd0, o_valid}, 0);
    chk("midrst_last", {31'd0, o_last}, 0);
    reset_n = 1'b0;
    idle(6);
    send_frame(61, -1, -1, 1'b0, 1'b0);
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
